// File: rtl/t09_game_ctrl.sv
// Snake game sequencer: paces head steps from the movement tick, samples the
// collision flags after settling, and keeps score, length and game state.
module t09_game_ctrl #(
    parameter int INIT_LEN = 2,
    parameter int MAX_LEN  = 50,
    parameter int LEN_W    = 7,
    parameter int SCORE_W  = 8
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               start,
    input  logic               pauseBtn,
    input  logic               moveTick,
    input  logic               goodColl,
    input  logic               badColl,
    input  logic               appleAck,
    output logic               stepEn,
    output logic               grow,
    output logic               appleReq,
    output logic [LEN_W-1:0]   snakeLen,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         gameState,
    output logic               gameOver,
    output logic               win
);

    // state  | meaning
    // IDLE   | after reset, waiting for start
    // RUN    | playing, waiting for a movement tick
    // STEP   | stepEn asserted, snake registers advance
    // SETTLE | collision checker registers the new head
    // CHECK  | collision flags sampled
    // APPLE  | appleReq held until appleAck
    // PAUSE  | play frozen, ticks dropped
    // OVER   | body/border hit, waiting for start
    // WIN    | MAX_LEN reached, shown as gameState 7 with win
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_RUN    = 4'd1,
        S_STEP   = 4'd2,
        S_SETTLE = 4'd3,
        S_CHECK  = 4'd4,
        S_APPLE  = 4'd5,
        S_PAUSE  = 4'd6,
        S_OVER   = 4'd7,
        S_WIN    = 4'd8
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_start_game;
    logic               w_eat;
    logic [LEN_W-1:0]   w_len_inc;
    logic [3:0]         w_nxt_code;

    logic               r_step;
    logic               r_grow;
    logic               r_req;
    logic               r_over;
    logic               r_win;
    logic [2:0]         r_gs;
    logic [LEN_W-1:0]   r_len;
    logic [SCORE_W-1:0] r_score;

    assign w_len_inc    = r_len + 1'b1;
    assign w_start_game = start && (r_state == S_IDLE || r_state == S_OVER || r_state == S_WIN);
    assign w_eat        = (r_state == S_CHECK) && goodColl && !badColl;
    assign w_nxt_code   = w_state_nxt;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_OVER, S_WIN: begin
                if (start) w_state_nxt = S_APPLE;
            end
            S_RUN: begin
                if (moveTick)      w_state_nxt = S_STEP;
                else if (pauseBtn) w_state_nxt = S_PAUSE;
            end
            S_PAUSE: begin
                if (pauseBtn) w_state_nxt = S_RUN;
            end
            S_STEP:   w_state_nxt = S_SETTLE;
            S_SETTLE: w_state_nxt = S_CHECK;
            S_CHECK: begin
                // a fatal hit wins over an apple seen in the same cycle
                if (badColl)       w_state_nxt = S_OVER;
                else if (goodColl) w_state_nxt = (w_len_inc == LEN_W'(MAX_LEN)) ? S_WIN : S_APPLE;
                else               w_state_nxt = S_RUN;
            end
            S_APPLE: begin
                if (appleAck) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_step  <= 1'b0;
            r_grow  <= 1'b0;
            r_req   <= 1'b0;
            r_over  <= 1'b0;
            r_win   <= 1'b0;
            r_gs    <= 3'd0;
            r_len   <= LEN_W'(INIT_LEN);
            r_score <= '0;
        end else begin
            r_step <= (w_state_nxt == S_STEP);
            r_grow <= w_eat;
            r_req  <= (w_state_nxt == S_APPLE);
            r_over <= (w_state_nxt == S_OVER);
            r_win  <= (w_state_nxt == S_WIN);
            r_gs   <= (w_state_nxt == S_WIN) ? 3'd7 : w_nxt_code[2:0];
            if (w_start_game) begin
                r_len   <= LEN_W'(INIT_LEN);
                r_score <= '0;
            end else if (w_eat) begin
                r_len <= w_len_inc;
                if (r_score != {SCORE_W{1'b1}}) r_score <= r_score + 1'b1;
            end
        end
    end

    assign stepEn    = r_step;
    assign grow      = r_grow;
    assign appleReq  = r_req;
    assign gameOver  = r_over;
    assign win       = r_win;
    assign gameState = r_gs;
    assign snakeLen  = r_len;
    assign score     = r_score;

endmodule

// File: tb/tb_t09_game_ctrl.sv
// Directed bench for t09_game_ctrl with MAX_LEN=4 so a win is reachable quickly.
module tb_t09_game_ctrl;

    logic       clk = 1'b0;
    logic       nRst;
    logic       start, pauseBtn, moveTick, goodColl, badColl, appleAck;
    logic       stepEn, grow, appleReq, gameOver, win;
    logic [6:0] snakeLen;
    logic [7:0] score;
    logic [2:0] gameState;

    int n_chk  = 0;
    int n_fail = 0;

    t09_game_ctrl #(.INIT_LEN(2), .MAX_LEN(4), .LEN_W(7), .SCORE_W(8)) dut (
        .clk(clk), .nRst(nRst), .start(start), .pauseBtn(pauseBtn),
        .moveTick(moveTick), .goodColl(goodColl), .badColl(badColl),
        .appleAck(appleAck), .stepEn(stepEn), .grow(grow), .appleReq(appleReq),
        .snakeLen(snakeLen), .score(score), .gameState(gameState),
        .gameOver(gameOver), .win(win)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // tick from RUN, drive collision flags during CHECK, return just after CHECK
    task automatic do_step(input logic g, input logic b);
        moveTick = 1'b1; cyc(); moveTick = 1'b0;
        cyc();
        cyc();
        chk("step_in_check", gameState, 4);
        goodColl = g; badColl = b;
        cyc();
        goodColl = 1'b0; badColl = 1'b0;
    endtask

    task automatic ack_apple();
        appleAck = 1'b1; cyc(); appleAck = 1'b0;
        chk("ack_state", gameState, 1);
        chk("ack_req", appleReq, 0);
    endtask

    initial begin
        nRst = 1'b0;
        {start, pauseBtn, moveTick, goodColl, badColl, appleAck} = '0;
        repeat (3) cyc();
        chk("rst_state", gameState, 0);
        chk("rst_step", stepEn, 0);
        chk("rst_grow", grow, 0);
        chk("rst_req", appleReq, 0);
        chk("rst_len", snakeLen, 2);
        chk("rst_score", score, 0);
        chk("rst_over", gameOver, 0);
        chk("rst_win", win, 0);
        nRst = 1'b1;
        cyc();

        start = 1'b1; cyc(); start = 1'b0;
        chk("start_state", gameState, 5);
        chk("start_req", appleReq, 1);
        chk("start_len", snakeLen, 2);
        chk("start_score", score, 0);
        ack_apple();

        moveTick = 1'b1; cyc(); moveTick = 1'b0;
        chk("t1_state", gameState, 2);
        chk("t1_step", stepEn, 1);
        cyc();
        chk("t2_state", gameState, 3);
        chk("t2_step", stepEn, 0);
        cyc();
        chk("t3_state", gameState, 4);
        cyc();
        chk("t4_state", gameState, 1);
        chk("t4_score", score, 0);

        do_step(1'b1, 1'b0);
        chk("eat_state", gameState, 5);
        chk("eat_score", score, 1);
        chk("eat_len", snakeLen, 3);
        chk("eat_grow", grow, 1);
        chk("eat_req", appleReq, 1);
        cyc();
        chk("eat_grow_end", grow, 0);
        repeat (9) cyc();
        chk("wait_state", gameState, 5);
        chk("wait_req", appleReq, 1);
        ack_apple();

        do_step(1'b1, 1'b1);
        chk("both_state", gameState, 7);
        chk("both_over", gameOver, 1);
        chk("both_win", win, 0);
        chk("both_score", score, 1);
        chk("both_len", snakeLen, 3);
        chk("both_grow", grow, 0);
        start = 1'b1; cyc(); start = 1'b0;
        chk("restart_state", gameState, 5);
        chk("restart_score", score, 0);
        chk("restart_len", snakeLen, 2);
        chk("restart_over", gameOver, 0);
        ack_apple();

        do_step(1'b1, 1'b0);
        chk("win1_len", snakeLen, 3);
        ack_apple();
        do_step(1'b1, 1'b0);
        chk("win_state", gameState, 7);
        chk("win_flag", win, 1);
        chk("win_over", gameOver, 0);
        chk("win_len", snakeLen, 4);
        chk("win_score", score, 2);
        chk("win_req", appleReq, 0);
        start = 1'b1; cyc(); start = 1'b0;
        chk("win_restart_state", gameState, 5);
        chk("win_restart_flag", win, 0);
        chk("win_restart_len", snakeLen, 2);
        ack_apple();

        pauseBtn = 1'b1; cyc(); pauseBtn = 1'b0;
        chk("pause_state", gameState, 6);
        for (int i = 0; i < 3; i++) begin
            moveTick = 1'b1; cyc(); moveTick = 1'b0;
            chk("pause_nostep", stepEn, 0);
            cyc();
            chk("pause_hold", gameState, 6);
        end
        pauseBtn = 1'b1; cyc(); pauseBtn = 1'b0;
        chk("unpause_state", gameState, 1);
        moveTick = 1'b1; pauseBtn = 1'b1; cyc();
        moveTick = 1'b0; pauseBtn = 1'b0;
        chk("tick_prio_state", gameState, 2);
        repeat (3) cyc();
        chk("tick_prio_back", gameState, 1);

        do_step(1'b0, 1'b1);
        chk("bad_state", gameState, 7);
        chk("bad_over", gameOver, 1);
        start = 1'b1; cyc(); start = 1'b0;
        chk("pre_rst_req", appleReq, 1);
        #1 nRst = 1'b0;
        #1;
        chk("mid_rst_state", gameState, 0);
        chk("mid_rst_req", appleReq, 0);
        chk("mid_rst_len", snakeLen, 2);
        chk("mid_rst_score", score, 0);
        chk("mid_rst_over", gameOver, 0);
        cyc();
        nRst = 1'b1;
        cyc();
        chk("post_rst_state", gameState, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
